borrow_skip_subtractor_seq: RTL
===============================

Name: borrow_skip_subtractor_seq

Overview:
- Multi-cycle N-bit subtractor computing diff = a - b - bin, one BLOCK-bit slice per clock, least-significant slice first.
- Uses block-level borrow skip: a slice whose bits all match (a == b) forwards its incoming borrow directly.
- This is the subtract-direction counterpart to the team's combinational carry-skip adder.
- Sits in the arithmetic datapath behind a valid/ready handshake on both input and output. It also reports borrow-out, signed overflow and the number of skipped slices.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of BLOCK (anything else is a configuration error).
- BLOCK, 4, slice width processed per cycle.
- NBLK (derived, not overridable), WIDTH/BLOCK, number of slices.
- CW (derived), clog2(NBLK+1), width of skip_cnt.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend (unsigned or two's complement)
- b  in  WIDTH  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  out  1  borrow out of MSB (1 when unsigned a < b + bin)
- ovf  out  1  signed overflow = borrow into MSB XOR borrow out of MSB
- skip_cnt  out  CW  number of slices whose borrow was taken via the skip path

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - diff, bout, ovf, skip_cnt and all internal registers = 0.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a clock edge: latch a, b and bin; clear slice index, skip_cnt and diff; go to RUN.
- RUN (in_ready = 0, out_valid = 0):
  - Each edge processes slice k = index, bits [k*BLOCK +: BLOCK], using the latched borrow br.
  - Per bit: d = a ^ b ^ br_i; br_(i+1) = (~a & b) | (~(a ^ b) & br_i).
  - Slice propagate P = AND over the slice of ~(a ^ b).
  - Slice borrow-out = P ? br_in : ripple borrow. The two are functionally equal; the skip mux must nevertheless be implemented.
  - If P = 1, skip_cnt increments.
  - On the final slice (k = NBLK-1): capture bout; capture ovf = (borrow into MSB) XOR bout; go to DONE.
- Latency: out_valid rises exactly NBLK clock edges after the accepting edge (4 for the defaults).
- DONE:
  - out_valid = 1; diff, bout, ovf and skip_cnt are held stable until the handshake.
  - On out_ready: go to IDLE. in_ready stays 0 during DONE, so there is no same-cycle re-accept; the next accept can occur one cycle later at the earliest.
- Throughput: one operation per NBLK+2 cycles when out_ready is held at 1.
- Input ports are ignored outside the IDLE accept edge. Changing a or b during RUN has no effect.
- out_ready while out_valid = 0 is ignored.
- diff wraps modulo 2^WIDTH. No saturation.

Test Plan:
- Reset mid-RUN: accept a = 0x1234, b = 0x0034, drop rst_n after 2 edges -> out_valid = 0, in_ready = 1, all outputs 0 immediately; a fresh accept afterwards gives correct results.
- a = 0x1234, b = 0x0034, bin = 0, out_ready = 1 -> out_valid 4 edges after accept; diff = 0x1200, bout = 0, ovf = 0, skip_cnt = 2.
- a = 0x0000, b = 0x0001, bin = 0 -> diff = 0xFFFF, bout = 1, ovf = 0, skip_cnt = 3.
- a = 0x8000, b = 0x0001, bin = 0 -> diff = 0x7FFF, bout = 0, ovf = 1, skip_cnt = 2.
- a = b = 0xABCD, bin = 1 -> diff = 0xFFFF, bout = 1, ovf = 0, skip_cnt = 4 (full skip chain). Hold out_ready = 0 for 5 cycles -> outputs stable and in_ready = 0 throughout; release -> IDLE the next cycle.
- Random back-to-back stream of 1000 operations, with in_valid and out_ready toggled randomly -> every result matches the reference model {bout, diff} = a - b - bin, plus the ovf and skip_cnt rules above; no operation is lost or duplicated.

Source files
------------

// File: rtl/borrow_skip_subtractor_seq_if.sv
// Handshake and operand/result bundle for the sequential borrow-skip subtractor.
// The master side feeds operands and consumes results.
// The slave side is the subtractor itself.
interface borrow_skip_subtractor_seq_if #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int CW   = $clog2(NBLK + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic [CW-1:0]    skip_cnt;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, skip_cnt
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, skip_cnt
    );
endinterface

// File: rtl/borrow_skip_subtractor_seq.sv
// Sequential subtractor: diff = a - b - bin, one BLOCK-bit slice per clock,
// least-significant slice first.
// A slice whose bits all match (a == b) has a propagate term of 1. Its borrow-out
// is then taken straight from its borrow-in through the skip mux, and the slice
// is counted in skip_cnt.
module borrow_skip_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    borrow_skip_subtractor_seq_if.slave   bus
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int CW   = $clog2(NBLK + 1);
    localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    // A width that is not a whole number of slices cannot be processed.
    generate
        if ((BLOCK < 1) || ((WIDTH % BLOCK) != 0)) begin : g_cfg_err
            $error("borrow_skip_subtractor_seq: WIDTH must be a multiple of BLOCK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             br_reg;
    logic [IW-1:0]    idx_reg;
    logic [CW-1:0]    skip_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             ovf_reg;

    logic             accept;
    logic             running;
    logic             last_slice;
    logic [BLOCK-1:0] a_blk [NBLK];
    logic [BLOCK-1:0] b_blk [NBLK];
    logic [BLOCK-1:0] a_s;
    logic [BLOCK-1:0] b_s;
    logic [BLOCK-1:0] d_s;
    logic [BLOCK:0]   br_chain;
    logic             p_s;
    logic             blk_bout;

    assign accept     = (state_reg == IDLE) && bus.in_valid;
    assign running    = (state_reg == RUN);
    assign last_slice = (idx_reg == IW'(NBLK - 1));

    // Split the latched operands into slices; the current slice is picked by index.
    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_split
            assign a_blk[gi] = a_reg[gi*BLOCK +: BLOCK];
            assign b_blk[gi] = b_reg[gi*BLOCK +: BLOCK];
        end
    endgenerate

    assign a_s = a_blk[idx_reg];
    assign b_s = b_blk[idx_reg];

    // Per-bit ripple borrow through the active slice.
    assign br_chain[0] = br_reg;
    generate
        for (genvar gi = 0; gi < BLOCK; gi++) begin : g_bit
            assign d_s[gi]          = a_s[gi] ^ b_s[gi] ^ br_chain[gi];
            assign br_chain[gi + 1] = (~a_s[gi] & b_s[gi])
                                    | (~(a_s[gi] ^ b_s[gi]) & br_chain[gi]);
        end
    endgenerate

    // Skip mux: a fully-propagating slice passes its incoming borrow straight on.
    assign p_s      = &(~(a_s ^ b_s));
    assign blk_bout = p_s ? br_reg : br_chain[BLOCK];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, running borrow, slice index, skip counter and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            br_reg   <= 1'b0;
            idx_reg  <= '0;
            skip_reg <= '0;
            bout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (accept) begin
            a_reg    <= bus.a;
            b_reg    <= bus.b;
            br_reg   <= bus.bin;
            idx_reg  <= '0;
            skip_reg <= '0;
            bout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (running) begin
            br_reg   <= blk_bout;
            idx_reg  <= idx_reg + 1'b1;
            skip_reg <= skip_reg + CW'(p_s);
            if (last_slice) begin
                bout_reg <= blk_bout;
                ovf_reg  <= br_chain[BLOCK-1] ^ blk_bout;
            end
        end
    end

    // Each slice of the result register is written only while its slice is active.
    generate
        for (genvar gi = 0; gi < NBLK; gi++) begin : g_diff
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    diff_reg[gi*BLOCK +: BLOCK] <= '0;
                end else if (accept) begin
                    diff_reg[gi*BLOCK +: BLOCK] <= '0;
                end else if (running && (idx_reg == IW'(gi))) begin
                    diff_reg[gi*BLOCK +: BLOCK] <= d_s;
                end
            end
        end
    endgenerate

    assign bus.diff     = diff_reg;
    assign bus.bout     = bout_reg;
    assign bus.ovf      = ovf_reg;
    assign bus.skip_cnt = skip_reg;

endmodule
